// File: rtl/rob_multi_commit.sv
// Reorder buffer with NUM_WB writeback ports and up to COMMIT_W in-order
// retirements per cycle; a retired mispredict raises a registered flush.
module rob_multi_commit #(
  parameter int ROB_LOG  = 4,
  parameter int NUM_WB   = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        issue_valid,
  input  logic [1:0]                  issue_kind,
  input  logic [4:0]                  issue_dest,
  output logic [ROB_LOG-1:0]          issue_id,
  output logic                        rob_full,
  output logic [ROB_LOG:0]            rob_count,
  input  logic [NUM_WB-1:0]           wb_valid,
  input  logic [NUM_WB*ROB_LOG-1:0]   wb_id,
  input  logic [NUM_WB*32-1:0]        wb_value,
  input  logic [NUM_WB-1:0]           wb_redirect,
  input  logic [NUM_WB*32-1:0]        wb_topc,
  output logic [COMMIT_W-1:0]         commit_valid,
  output logic [COMMIT_W*5-1:0]       commit_dest,
  output logic [COMMIT_W*ROB_LOG-1:0] commit_id,
  output logic [COMMIT_W*32-1:0]      commit_value,
  output logic                        store_commit,
  output logic [ROB_LOG-1:0]          store_commit_id,
  output logic                        flush,
  output logic [31:0]                 flush_pc
);

  localparam int               DEPTH   = 1 << ROB_LOG;
  localparam logic [ROB_LOG:0] DEPTH_C = (ROB_LOG+1)'(DEPTH);
  localparam logic [1:0]       KIND_REG = 2'd0;
  localparam logic [1:0]       KIND_BR  = 2'd1;
  localparam logic [1:0]       KIND_ST  = 2'd2;

  logic [ROB_LOG-1:0] head, tail;
  logic [ROB_LOG:0]   count;
  logic [DEPTH-1:0]   ent_valid, ent_ready, ent_redir;
  logic [1:0]         ent_kind  [DEPTH];
  logic [4:0]         ent_dest  [DEPTH];
  logic [31:0]        ent_value [DEPTH];
  logic [31:0]        ent_topc  [DEPTH];

  logic [ROB_LOG-1:0] slot_idx [COMMIT_W];
  logic [COMMIT_W-1:0] ret_p0;
  logic [ROB_LOG:0]   nret_p0;
  logic               flush_now_p0;
  logic [31:0]        flush_tgt_p0;
  logic               store_ret_p0;
  logic [ROB_LOG-1:0] store_idx_p0;
  logic               chain;
  logic               issue_ok;

  assign issue_id  = tail;
  assign rob_count = count;
  assign rob_full  = (count >= DEPTH_C - (ROB_LOG+1)'(1));
  assign issue_ok  = issue_valid && (count < DEPTH_C) && !flush;

  for (genvar g = 0; g < COMMIT_W; g++) begin : g_slot
    assign slot_idx[g] = head + ROB_LOG'(g);
  end

  // Stage p0: retire selection from registered entry state
  always_comb begin
    ret_p0       = '0;
    nret_p0      = '0;
    flush_now_p0 = 1'b0;
    flush_tgt_p0 = '0;
    store_ret_p0 = 1'b0;
    store_idx_p0 = '0;
    chain        = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      if (chain && ent_valid[slot_idx[k]] && ent_ready[slot_idx[k]] &&
          !(store_ret_p0 && ent_kind[slot_idx[k]] == KIND_ST)) begin
        ret_p0[k] = 1'b1;
        nret_p0   = nret_p0 + (ROB_LOG+1)'(1);
        if (ent_kind[slot_idx[k]] == KIND_ST) begin
          store_ret_p0 = 1'b1;
          store_idx_p0 = slot_idx[k];
        end
        // A redirecting entry retires itself but stops younger slots.
        if (ent_redir[slot_idx[k]]) begin
          flush_now_p0 = 1'b1;
          flush_tgt_p0 = ent_topc[slot_idx[k]];
          chain        = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // Stage p1: registered commit outputs and pointer/bookkeeping update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      ent_valid       <= '0;
      ent_ready       <= '0;
      ent_redir       <= '0;
      commit_valid    <= '0;
      commit_dest     <= '0;
      commit_id       <= '0;
      commit_value    <= '0;
      store_commit    <= 1'b0;
      store_commit_id <= '0;
      flush           <= 1'b0;
      flush_pc        <= '0;
    end else begin
      commit_valid <= '0;
      store_commit <= 1'b0;
      flush        <= 1'b0;
      if (rdy) begin
        for (int k = 0; k < COMMIT_W; k++) begin
          if (ret_p0[k]) begin
            commit_valid[k]                 <= (ent_kind[slot_idx[k]] == KIND_REG);
            commit_dest[k*5 +: 5]           <= ent_dest[slot_idx[k]];
            commit_id[k*ROB_LOG +: ROB_LOG] <= slot_idx[k];
            commit_value[k*32 +: 32]        <= ent_value[slot_idx[k]];
          end
        end
        store_commit <= store_ret_p0;
        if (store_ret_p0) store_commit_id <= store_idx_p0;
        if (flush_now_p0) begin
          flush     <= 1'b1;
          flush_pc  <= flush_tgt_p0;
          head      <= '0;
          tail      <= '0;
          count     <= '0;
          ent_valid <= '0;
        end else begin
          for (int w = 0; w < NUM_WB; w++) begin
            if (wb_valid[w] && ent_valid[wb_id[w*ROB_LOG +: ROB_LOG]]) begin
              ent_ready[wb_id[w*ROB_LOG +: ROB_LOG]] <= 1'b1;
              ent_redir[wb_id[w*ROB_LOG +: ROB_LOG]] <= wb_redirect[w];
            end
          end
          for (int k = 0; k < COMMIT_W; k++) begin
            if (ret_p0[k]) ent_valid[slot_idx[k]] <= 1'b0;
          end
          if (issue_ok) begin
            ent_valid[tail] <= 1'b1;
            ent_ready[tail] <= 1'b0;
            ent_redir[tail] <= 1'b0;
            tail            <= tail + ROB_LOG'(1);
          end
          head  <= head + nret_p0[ROB_LOG-1:0];
          count <= count + (ROB_LOG+1)'(issue_ok) - nret_p0;
        end
      end
    end
  end

  // Payload storage is never reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (rdy && !flush_now_p0) begin
      for (int w = 0; w < NUM_WB; w++) begin
        if (wb_valid[w] && ent_valid[wb_id[w*ROB_LOG +: ROB_LOG]]) begin
          ent_value[wb_id[w*ROB_LOG +: ROB_LOG]] <= wb_value[w*32 +: 32];
          ent_topc[wb_id[w*ROB_LOG +: ROB_LOG]]  <= wb_topc[w*32 +: 32];
        end
      end
      if (issue_ok) begin
        ent_kind[tail] <= (issue_kind == 2'd3) ? KIND_BR : issue_kind;
        ent_dest[tail] <= issue_dest;
      end
    end
  end

  no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    !(rdy && issue_valid && !flush && count == DEPTH_C));

endmodule

// File: doc/rob_multi_commit.md
Name: rob_multi_commit

Overview:
- Parametrised reorder buffer and successor to the single-commit ROB.
- Allocates entries in program order at issue and accepts NUM_WB independent writeback ports.
- Retires up to COMMIT_W ready entries per cycle, in order, to the register file and the store path.
- Raises a registered flush/redirect on a committed mispredict; sits between issue/decode, the execution units (ALU, LSB) and the regfile/IF.

Parameters:
- ROB_LOG, 4, log2 of depth; DEPTH = 2^ROB_LOG, all slots usable.
- NUM_WB, 2, number of writeback ports.
- COMMIT_W, 2, maximum retirements per cycle (1 or 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- issue_valid  in  1  allocate one entry at tail.
- issue_kind  in  2  0=reg-write, 1=branch (no reg write), 2=store, 3=reserved (treated as 1).
- issue_dest  in  5  destination register for kind 0.
- issue_id  out  ROB_LOG  combinational tail index that the next issue will receive.
- rob_full  out  1  combinational: count >= DEPTH-1.
- rob_count  out  ROB_LOG+1  occupied entries.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_id  in  NUM_WB*ROB_LOG  target entry per port.
- wb_value  in  NUM_WB*32  result value.
- wb_redirect  in  NUM_WB  entry mispredicted; flush on commit.
- wb_topc  in  NUM_WB*32  correct PC when wb_redirect=1.
- commit_valid  out  COMMIT_W  registered per-slot regfile write pulse.
- commit_dest  out  COMMIT_W*5  destination register per slot.
- commit_id  out  COMMIT_W*ROB_LOG  ROB index per slot, used for rename-tag clear.
- commit_value  out  COMMIT_W*32  result value per slot.
- store_commit  out  1  registered pulse: LSB may perform the store.
- store_commit_id  out  ROB_LOG  entry of that store.
- flush  out  1  registered one-cycle redirect pulse.
- flush_pc  out  32  redirect target.

Behaviour:
- Reset (async): head=tail=0, count=0, all entry ready/valid bits 0, every output register 0.
- rdy=0: no state changes; commit_valid, store_commit and flush drive 0 on the next edge.
- Issue: accepted when issue_valid and count<DEPTH and flush=0.
  - Writes kind/dest at tail, clears ready and redirect, sets valid, tail=tail+1 mod DEPTH.
  - Issue while count==DEPTH is a protocol error (assertion).
  - issue_valid during the flush=1 cycle is dropped.
- Writeback: for each port with wb_valid and valid[wb_id], set ready and store value, redirect and topc.
  - Writeback to an invalid entry is ignored.
  - Two ports targeting the same id in one cycle: highest port index wins.
  - Writeback to the head entry in cycle N is visible to commit no earlier than cycle N+1.
- Commit, evaluated on registered state each cycle:
  - slot0 = head, retires if valid and ready.
  - slot k (k≥1) retires only if slot k-1 retired, slot k-1 had no redirect, and the entry is valid and ready.
  - At most one store per cycle: a store in slot k≥1 retires only if no earlier slot this cycle was a store.
- Retired outputs:
  - kind 0 → commit_valid[k]=1 with dest, id and value, including a redirecting kind-0 entry (JALR).
  - kind 2 → store_commit=1 with its id; commit_valid[k]=0.
  - kind 1 → no regfile write.
- All commit outputs are registered: one cycle after the entry is ready at head.
- Pointers and count: head advances by the number retired; count_next = count + issued − retired, and simultaneous issue and retire is legal.
- Redirect:
  - Retiring an entry with redirect=1 sets flush=1 and flush_pc=topc on that edge.
  - On the same edge all entries are invalidated and head=tail=count=0; the cycle's issue and writebacks are discarded.
  - flush returns to 0 next cycle unless a new redirect occurs, which is impossible while the ROB is empty.
- Wrap-around: indices modulo DEPTH; full state (count=DEPTH, head==tail) is distinguished from empty by count.

Test Plan:
- After reset, issue 3 kind-0 entries (dest 1,2,3), writeback ids 0,1,2 in one cycle on ports 0/1/then 0 → cycle+1: commit ids 0,1; cycle+2: commit id 2; rob_count goes 3→1→0.
- Fill DEPTH=16 entries with no writeback → rob_full=1 at count 15; count stays 16; writeback all, then ready drains 2 per cycle over 8 cycles; head wraps to 0.
- Two adjacent stores at head, both ready → store_commit on two consecutive cycles, ids in order; never both in one cycle.
- Branch at id 1 with redirect, topc=0x100; ids 0, 1, 2 ready → ids 0 and 1 retire, flush=1 with flush_pc=0x100; id 2 never commits; count=0 and issue_id=0 next cycle.
- Ports 0 and 1 both write id 4 with 0xAAAA and 0xBBBB → committed value 0xBBBB.
- Hold rdy=0 for 3 cycles with a ready head → no commit pulses and state unchanged; commit follows the first cycle after rdy=1. Then assert rst asynchronously mid-stream → all outputs 0 before the next clk edge.
